// File: rtl/photon_inv_perm_if.sv
// Handshake bundle for photon_inv_perm: input state in, inverted state out.
interface photon_inv_perm_if;
   logic        in_valid;
   logic        in_ready;
   logic [99:0] state_in;
   logic        out_valid;
   logic        out_ready;
   logic [99:0] state_out;

   modport master (
      output in_valid, state_in, out_ready,
      input  in_ready, out_valid, state_out
   );

   modport slave (
      input  in_valid, state_in, out_ready,
      output in_ready, out_valid, state_out
   );
endinterface

// File: rtl/photon_inv_perm.sv
// Iterative inverse PHOTON-80/20/16 permutation, 5x5 nibble state over GF(2^4).
// Define PHOTON_INV_FAST_MIX_EN to unroll the five serial mix steps per round.
module photon_inv_perm #(
   parameter int ROUNDS = 12
) (
   input logic            clk,
   input logic            rst,
   photon_inv_perm_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MIX, SUB, DONE} state_t;

   state_t      st, st_nx;
   logic [99:0] q, q_nx;
   logic [3:0]  rnd, rnd_nx;
   logic [2:0]  step, step_nx;

   function automatic logic [3:0] xt(input logic [3:0] x);
      return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] m9(input logic [3:0] x);
      return xt(xt(xt(x))) ^ x;
   endfunction

   function automatic logic [3:0] isbox(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;
         4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;
         4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;
         4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;
         4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] rc(input logic [3:0] r);
      logic [3:0] y;
      case (r)
         4'd0: y = 4'h1;  4'd1: y = 4'h3;
         4'd2: y = 4'h7;  4'd3: y = 4'hE;
         4'd4: y = 4'hD;  4'd5: y = 4'hB;
         4'd6: y = 4'h6;  4'd7: y = 4'hC;
         4'd8: y = 4'h9;  4'd9: y = 4'h2;
         4'd10: y = 4'h5; 4'd11: y = 4'hA;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] ic(input int r);
      logic [3:0] y;
      case (r)
         1: y = 4'h1;
         2: y = 4'h3;
         3: y = 4'h6;
         4: y = 4'h4;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   // One inverse serial step on every column: (a0..a4) -> (t,a0..a3)
   function automatic logic [99:0] mix_step(input logic [99:0] s);
      logic [99:0] o;
      logic [3:0]  a [5];
      o = s;
      for (int c = 0; c < 5; c++) begin
         for (int r = 0; r < 5; r++)
            a[r] = s[99-20*r-4*c -: 4];
         o[99-4*c -: 4] = a[4] ^ xt(a[0]) ^ m9(a[1])
                        ^ m9(a[2]) ^ xt(a[3]);
         for (int r = 1; r < 5; r++)
            o[99-20*r-4*c -: 4] = a[r-1];
      end
      return o;
   endfunction

   function automatic logic [99:0] mix_all(input logic [99:0] s);
      logic [99:0] o;
      o = s;
      for (int k = 0; k < 5; k++)
         o = mix_step(o);
      return o;
   endfunction

   // Row rotate right, inverse S-box, then strip the round constants
   function automatic logic [99:0] sub_layer(
      input logic [99:0] s,
      input logic [3:0]  rd
   );
      logic [99:0] o;
      logic [3:0]  v;
      o = '0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            v = isbox(s[99-20*r-4*((c+5-r)%5) -: 4]);
            if (c == 0)
               v = v ^ rc(rd) ^ ic(r);
            o[99-20*r-4*c -: 4] = v;
         end
      end
      return o;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st   <= IDLE;
         q    <= '0;
         rnd  <= '0;
         step <= '0;
      end else begin
         st   <= st_nx;
         q    <= q_nx;
         rnd  <= rnd_nx;
         step <= step_nx;
      end
   end

   always_comb begin
      st_nx   = st;
      q_nx    = q;
      rnd_nx  = rnd;
      step_nx = step;
      unique case (st)
         IDLE: begin
            if (bus.in_valid) begin
               q_nx    = bus.state_in;
               rnd_nx  = 4'(ROUNDS - 1);
               step_nx = '0;
               st_nx   = MIX;
            end
         end
         MIX: begin
`ifdef PHOTON_INV_FAST_MIX_EN
            q_nx  = mix_all(q);
            st_nx = SUB;
`else
            q_nx    = mix_step(q);
            step_nx = step + 3'd1;
            if (step == 3'd4)
               st_nx = SUB;
`endif
         end
         SUB: begin
            q_nx = sub_layer(q, rnd);
            if (rnd == 4'd0) begin
               st_nx = DONE;
            end else begin
               rnd_nx  = rnd - 4'd1;
               step_nx = '0;
               st_nx   = MIX;
            end
         end
         DONE: begin
            if (bus.out_ready)
               st_nx = IDLE;
         end
         default: st_nx = IDLE;
      endcase
   end

   assign bus.in_ready  = (st == IDLE);
   assign bus.out_valid = (st == DONE);
   assign bus.state_out = q;

endmodule

// File: tb/tb_photon_inv_perm.sv
// Bench for photon_inv_perm: round-trips states through a forward PHOTON model.
module tb_photon_inv_perm;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total = 0;

`ifdef PHOTON_INV_FAST_MIX_EN
   localparam int PER_RND = 2;
`else
   localparam int PER_RND = 6;
`endif
   localparam int LAT12 = PER_RND * 12;
   localparam int LAT1  = PER_RND;

   photon_inv_perm_if b12 ();
   photon_inv_perm_if b1 ();

   photon_inv_perm #(.ROUNDS(12)) dut12 (
      .clk(clk), .rst(rst), .bus(b12)
   );
   photon_inv_perm #(.ROUNDS(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 4; i++)
         if (b[i]) p = p ^ (8'(a) << i);
      for (int i = 7; i >= 4; i--)
         if (p[i]) p = p ^ (8'h13 << (i - 4));
      return p[3:0];
   endfunction

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [63:0] t;
      t = 64'hC56B90AD3EF84712;
      return t[63-4*x -: 4];
   endfunction

   function automatic logic [3:0] rc_of(input int r);
      logic [47:0] t;
      t = 48'h137EDB6C925A;
      return t[47-4*r -: 4];
   endfunction

   function automatic logic [3:0] ic_of(input int r);
      logic [19:0] t;
      t = 20'h01364;
      return t[19-4*r -: 4];
   endfunction

   // Forward PHOTON permutation, rounds 0..nr-1
   function automatic logic [99:0] fwd(input logic [99:0] x, input int nr);
      logic [3:0]  m [5][5];
      logic [3:0]  t [5][5];
      logic [3:0]  b [5];
      logic [3:0]  n;
      logic [99:0] y;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            m[r][c] = x[99-20*r-4*c -: 4];
      for (int k = 0; k < nr; k++) begin
         for (int i = 0; i < 5; i++)
            m[i][0] = m[i][0] ^ rc_of(k) ^ ic_of(i);
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
               m[i][j] = sbox(m[i][j]);
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
               t[i][j] = m[i][(j+i)%5];
         for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 5; i++) b[i] = t[i][j];
            for (int s = 0; s < 5; s++) begin
               n = b[0] ^ gmul(4'd2, b[1]) ^ gmul(4'd9, b[2])
                 ^ gmul(4'd9, b[3]) ^ gmul(4'd2, b[4]);
               b[0] = b[1]; b[1] = b[2]; b[2] = b[3];
               b[3] = b[4]; b[4] = n;
            end
            for (int i = 0; i < 5; i++) m[i][j] = b[i];
         end
      end
      y = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            y[99-20*r-4*c -: 4] = m[r][c];
      return y;
   endfunction

   function automatic logic [99:0] rand100();
      logic [127:0] v;
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      return v[99:0];
   endfunction

   // Submit one state to the 12-round instance; returns result and latency
   task automatic op12(input logic [99:0] v, output logic [99:0] y,
                       output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!b12.in_ready && w < 200) begin
         @(negedge clk); w++;
      end
      b12.in_valid = 1'b1;
      b12.state_in = v;
      @(negedge clk);
      b12.in_valid = 1'b0;
      lat = 0;
      while (!b12.out_valid && lat < 200) begin
         @(negedge clk); lat++;
      end
      y = b12.state_out;
      b12.out_ready = 1'b1;
      @(negedge clk);
      b12.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (b12.in_ready !== 1'b1 || b12.out_valid !== 1'b0)
         $display("FAIL reset_hs12 rdy=%b vld=%b want 1/0",
                  b12.in_ready, b12.out_valid);
      else pass_cnt++;
      total++;
      if (b12.state_out !== 100'h0)
         $display("FAIL reset_out12 got %h want 0", b12.state_out);
      else pass_cnt++;
      total++;
      if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.state_out !== 100'h0)
         $display("FAIL reset_1 rdy=%b vld=%b out=%h", b1.in_ready,
                  b1.out_valid, b1.state_out);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_one_round();
      logic [99:0] want;
      int lat;
      want = 100'h45555_55555_75555_25555_05555;
      @(negedge clk);
      b1.in_valid = 1'b1;
      b1.state_in = '0;
      @(negedge clk);
      b1.in_valid = 1'b0;
      lat = 0;
      while (!b1.out_valid && lat < 100) begin
         @(negedge clk); lat++;
      end
      total++;
      if (lat !== LAT1)
         $display("FAIL r1_latency got %0d want %0d", lat, LAT1);
      else pass_cnt++;
      total++;
      if (b1.state_out !== want)
         $display("FAIL r1_value got %h want %h", b1.state_out, want);
      else pass_cnt++;
      b1.out_ready = 1'b1;
      @(negedge clk);
      b1.out_ready = 1'b0;
   endtask

   task automatic test_golden();
      logic [99:0] xs [2];
      logic [99:0] y;
      int lat;
      xs[0] = '0;
      xs[1] = 100'h0123456789ABCDEF0123F;
      for (int i = 0; i < 2; i++) begin
         op12(fwd(xs[i], 12), y, lat);
         total++;
         if (y !== xs[i])
            $display("FAIL golden%0d got %h want %h", i, y, xs[i]);
         else pass_cnt++;
         total++;
         if (lat !== LAT12)
            $display("FAIL golden%0d_lat got %0d want %0d", i, lat, LAT12);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [99:0] x, y;
      int lat;
      for (int i = 0; i < 1000; i++) begin
         x = rand100();
         op12(fwd(x, 12), y, lat);
         total++;
         if (y !== x || lat !== LAT12)
            $display("FAIL rand%0d got %h lat %0d want %h lat %0d",
                     i, y, lat, x, LAT12);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic [99:0] x;
      int lat;
      x = rand100();
      @(negedge clk);
      b12.in_valid = 1'b1;
      b12.state_in = fwd(x, 12);
      @(negedge clk);
      b12.in_valid = 1'b0;
      lat = 0;
      while (!b12.out_valid && lat < 200) begin
         @(negedge clk); lat++;
      end
      for (int i = 0; i < 20; i++) begin
         total++;
         if (b12.out_valid !== 1'b1 || b12.in_ready !== 1'b0 ||
             b12.state_out !== x)
            $display("FAIL bp_hold%0d vld=%b rdy=%b out=%h want %h",
                     i, b12.out_valid, b12.in_ready, b12.state_out, x);
         else pass_cnt++;
         @(negedge clk);
      end
      b12.out_ready = 1'b1;
      @(negedge clk);
      b12.out_ready = 1'b0;
      total++;
      if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1)
         $display("FAIL bp_release vld=%b rdy=%b want 0/1",
                  b12.out_valid, b12.in_ready);
      else pass_cnt++;
   endtask

   task automatic test_in_valid_hold();
      logic [99:0] x;
      int n;
      int bad;
      x = rand100();
      @(negedge clk);
      b12.in_valid = 1'b1;
      b12.state_in = fwd(x, 12);
      @(negedge clk);
      n = 0;
      bad = 0;
      while (!b12.out_valid && n < 200) begin
         if (b12.in_ready !== 1'b0) bad++;
         b12.state_in = rand100();
         @(negedge clk); n++;
      end
      total++;
      if (bad != 0 || n !== LAT12)
         $display("FAIL hold_ready ready_hi=%0d lat=%0d want 0/%0d",
                  bad, n, LAT12);
      else pass_cnt++;
      total++;
      if (b12.state_out !== x || b12.in_ready !== 1'b0)
         $display("FAIL hold_value got %h rdy=%b want %h",
                  b12.state_out, b12.in_ready, x);
      else pass_cnt++;
      b12.in_valid = 1'b0;
      b12.out_ready = 1'b1;
      @(negedge clk);
      b12.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [99:0] x, y;
      int lat;
      x = rand100();
      @(negedge clk);
      b12.in_valid = 1'b1;
      b12.state_in = fwd(x, 12);
      @(negedge clk);
      b12.in_valid = 1'b0;
      repeat (29) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b1 ||
          b12.state_out !== 100'h0)
         $display("FAIL mid_reset vld=%b rdy=%b out=%h want 0/1/0",
                  b12.out_valid, b12.in_ready, b12.state_out);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      x = rand100();
      op12(fwd(x, 12), y, lat);
      total++;
      if (y !== x || lat !== LAT12)
         $display("FAIL after_reset got %h lat %0d want %h lat %0d",
                  y, lat, x, LAT12);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [99:0] xs [$];
      logic [99:0] exp_q [$];
      logic [99:0] e;
      int sent, got, last, cyc;
      sent = 0; got = 0; last = -1; cyc = 0;
      for (int i = 0; i < 4; i++) xs.push_back(rand100());
      @(negedge clk);
      b12.out_ready = 1'b1;
      b12.in_valid = 1'b1;
      b12.state_in = fwd(xs[0], 12);
      while (got < 4 && cyc < 1000) begin
         if (b12.in_valid && b12.in_ready) begin
            exp_q.push_back(xs[sent]);
            sent++;
         end
         if (b12.out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (b12.state_out !== e)
               $display("FAIL b2b_value%0d got %h want %h",
                        got, b12.state_out, e);
            else pass_cnt++;
            if (last >= 0) begin
               total++;
               if (cyc - last != LAT12 + 2)
                  $display("FAIL b2b_period%0d got %0d want %0d",
                           got, cyc - last, LAT12 + 2);
               else pass_cnt++;
            end
            last = cyc;
            got++;
         end
         @(negedge clk);
         cyc++;
         if (sent < 4) b12.state_in = fwd(xs[sent], 12);
         else b12.in_valid = 1'b0;
      end
      total++;
      if (got != 4)
         $display("FAIL b2b_timeout got %0d results want 4", got);
      else pass_cnt++;
      b12.in_valid = 1'b0;
      b12.out_ready = 1'b0;
   endtask

   initial begin
      b12.in_valid = 1'b0; b12.state_in = '0; b12.out_ready = 1'b0;
      b1.in_valid = 1'b0;  b1.state_in = '0;  b1.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_one_round();
      test_golden();
      test_backpressure();
      test_in_valid_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/photon_inv_perm.md
Name: photon_inv_perm

Overview:
- Iterative inverse of the PHOTON-80/20/16 permutation on a 100-bit state: a 5x5 matrix of 4-bit cells over GF(2^4) with polynomial x^4+x+1.
- It is the decrypt/verify-direction counterpart of the forward round datapath (AddConstants, SubCells, ShiftRows, MixColumnsSerial).
- It accepts a state over a valid/ready handshake, runs the inverse rounds from the highest round down to 0, and presents the result over a second valid/ready handshake.

Parameters:
- ROUNDS, 12, number of inverse rounds executed; legal range 1..12. The block runs round indices ROUNDS-1 down to 0.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state (high only in IDLE)
- state_in  input  100  permuted state to invert
- out_valid  output  1  state_out holds the result
- out_ready  input  1  consumer accepts state_out
- state_out  output  100  inverted state; driven directly from the state register

Behaviour:
- Cell layout: cell(r,c) = state[99-20r-4c -: 4]. Row 0 is at the MSBs, column 0 is the leftmost nibble of each row.
- Reset: FSM=IDLE, state register=0, round=0, step=0, in_ready=1, out_valid=0.
- FSM states: IDLE, MIX, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load state_in, set round=ROUNDS-1, step=0, go to MIX.
- MIX:
  - Each cycle applies one inverse serial step to all 5 columns in parallel.
  - For column values (a0..a4), the new column is (t,a0,a1,a2,a3), where t = a4 ^ 2·a0 ^ 9·a1 ^ 9·a2 ^ 2·a3.
  - GF multiplies: 2·x = xtime(x) reduced by 0x13; 9·x = xtime^3(x) ^ x.
  - step increments each cycle; after step 4 (5 steps total) go to SUB.
- SUB, in one cycle:
  - Inverse ShiftRows: rotate row r right by r cells.
  - Inverse S-box on every cell, with table 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A for inputs 0..F.
  - Then cell(i,0) ^= RC[round] ^ IC[i].
  - RC = 1,3,7,E,D,B,6,C,9,2,5,A for round indices 0..11. IC = 0,1,3,6,4.
  - If round==0, go to DONE; otherwise round-1, step=0, go to MIX.
- DONE:
  - out_valid=1 and state_out is held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of a new input with an unconsumed result.
- Latency: 6·ROUNDS clock edges from the accepting edge to out_valid high (72 at default).
- in_valid is ignored outside IDLE; state_in may change freely once it has been accepted.
- Backpressure: out_ready low holds DONE indefinitely with no change to state_out.
- Reset mid-operation: an immediate return to reset values. No partial result is ever flagged valid.
- Round counter is 4 bits, step counter 3 bits; no wrap-around occurs within the legal ROUNDS range.

Optional Feature:
- Macro: PHOTON_INV_FAST_MIX_EN.
- Defined:
  - MIX does all 5 serial steps combinationally in a single cycle (unrolled), then moves to SUB.
  - Latency becomes 2·ROUNDS edges (24 at default); the step counter is unused.
- Undefined: one serial step per cycle as specified above; smaller area.
- Results are bit-identical in both builds.

Test Plan:
- ROUNDS=1, state_in=0 -> after 6 edges (2 when fast) out_valid=1, state_out=0x45555_55555_75555_25555_05555.
- ROUNDS=12, state_in = forward golden P(0) and P(0x0123456789ABCDEF0123F), plus 1000 random states fed from the golden P(x) -> state_out==x. out_valid rises exactly 72 edges (24 when fast) after acceptance.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid -> state_out stable, in_ready=0 throughout.
  - Raise out_ready -> one-cycle handshake, then in_ready=1 on the next cycle.
- in_valid asserted continuously with changing state_in during the run -> only the first value is processed; in_ready=0 until back in IDLE.
- Assert rst asynchronously (between edges) at cycle 30 of a run -> outputs reset immediately. The next accepted vector produces the correct result with full latency.
- Back-to-back with out_ready tied high -> results return in order, one per 6·ROUNDS+2 cycles, with no corruption between consecutive operations.
